// File: rtl/fb_read_arbiter.sv
// ---------------------------------------------------------------------------
// fb_read_arbiter
//
// Purpose:
//   Shares the single Avalon-MM burst-read master of the SDRAM controller
//   between two read requesters in the 60 MHz clk domain.
//     - Port 0 (HDMI scanline fetcher) has fixed priority.
//     - Port 1 (secondary reader such as DMA / overlay fetch) is protected
//       from starvation: after MAX_STREAK consecutive port-0 grants taken
//       while port 1 was waiting, port 1 wins the next arbitration.
//   Only one burst is ever outstanding. The grant is held until every beat
//   of that burst has come back from the SDRAM.
//
// Ports:
//   clk                  system clock, shared with the SDRAM master
//   reset                asynchronous, active-low reset
//   s0_* / s1_*          Avalon-MM burst-read slave ports for the requesters
//                        (read, address, burstcount in; waitrequest,
//                        readdata, readdatavalid out)
//   m_*                  Avalon-MM burst-read master towards the SDRAM
//                        (read, address, burstcount, byteenable out;
//                        waitrequest, readdata, readdatavalid in)
//   grant                one-hot owner: 01 = port 0, 10 = port 1, 00 = none
//   busy                 high while a burst is being issued or returned
// ---------------------------------------------------------------------------
module fb_read_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int BURST_W    = 11,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               s0_read,
    input  logic [ADDR_W-1:0]  s0_address,
    input  logic [BURST_W-1:0] s0_burstcount,
    output logic               s0_waitrequest,
    output logic [31:0]        s0_readdata,
    output logic               s0_readdatavalid,

    input  logic               s1_read,
    input  logic [ADDR_W-1:0]  s1_address,
    input  logic [BURST_W-1:0] s1_burstcount,
    output logic               s1_waitrequest,
    output logic [31:0]        s1_readdata,
    output logic               s1_readdatavalid,

    output logic               m_read,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic [3:0]         m_byteenable,
    input  logic               m_waitrequest,
    input  logic [31:0]        m_readdata,
    input  logic               m_readdatavalid,

    output logic [1:0]         grant,
    output logic               busy
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    localparam logic [BURST_W-1:0]  BURST_ONE  = BURST_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 r_mRead;
    logic                 w_mReadNext;
    logic [ADDR_W-1:0]    r_mAddress;
    logic [ADDR_W-1:0]    w_mAddressNext;
    logic [BURST_W-1:0]   r_mBurstcount;
    logic [BURST_W-1:0]   w_mBurstcountNext;
    logic [1:0]           r_grant;
    logic [1:0]           w_grantNext;
    logic [BURST_W-1:0]   r_beatCnt;
    logic [BURST_W-1:0]   w_beatCntNext;
    logic [STREAK_W-1:0]  r_streak;
    logic [STREAK_W-1:0]  w_streakNext;

    logic                 w_pickP1;
    logic                 w_pickP0;
    logic [BURST_W-1:0]   w_s0Burst;
    logic [BURST_W-1:0]   w_s1Burst;
    logic                 w_lastBeat;

    // Arbitration decision, only acted on in IDLE. Port 1 normally yields to
    // port 0, except when port 0 has already used up its streak allowance.
    assign w_pickP1 = s1_read && (!s0_read || (r_streak == STREAK_MAX));
    assign w_pickP0 = !w_pickP1 && s0_read;

    // A zero burstcount is not a legal Avalon burst, so it is issued as a
    // single beat; otherwise the burst would never terminate.
    assign w_s0Burst = (s0_burstcount == '0) ? BURST_ONE : s0_burstcount;
    assign w_s1Burst = (s1_burstcount == '0) ? BURST_ONE : s1_burstcount;

    // The final beat is recognised before the counter increments, so the
    // grant drops on the same edge that accepts the last beat.
    assign w_lastBeat = m_readdatavalid && (r_beatCnt == (r_mBurstcount - BURST_ONE));

    // State and command registers. Reset returns everything to an idle,
    // ungranted master immediately, even in the middle of a burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_mRead       <= 1'b0;
            r_mAddress    <= '0;
            r_mBurstcount <= '0;
            r_grant       <= GRANT_NONE;
            r_beatCnt     <= '0;
            r_streak      <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_mRead       <= w_mReadNext;
            r_mAddress    <= w_mAddressNext;
            r_mBurstcount <= w_mBurstcountNext;
            r_grant       <= w_grantNext;
            r_beatCnt     <= w_beatCntNext;
            r_streak      <= w_streakNext;
        end
    end

    // Next-state logic. The command registers hold their values by default;
    // the address and burstcount are only sampled at grant time so a
    // requester changing them while stalled has no effect.
    always_comb begin
        w_stateNext       = r_state;
        w_mReadNext       = r_mRead;
        w_mAddressNext    = r_mAddress;
        w_mBurstcountNext = r_mBurstcount;
        w_grantNext       = r_grant;
        w_beatCntNext     = r_beatCnt;
        w_streakNext      = r_streak;

        case (r_state)
            IDLE: begin
                if (w_pickP1) begin
                    w_mAddressNext    = s1_address;
                    w_mBurstcountNext = w_s1Burst;
                    w_grantNext       = GRANT_P1;
                    w_mReadNext       = 1'b1;
                    w_streakNext      = '0;
                    w_stateNext       = CMD;
                end else if (w_pickP0) begin
                    w_mAddressNext    = s0_address;
                    w_mBurstcountNext = w_s0Burst;
                    w_grantNext       = GRANT_P0;
                    w_mReadNext       = 1'b1;
                    // The streak only grows while port 1 is actually waiting
                    // and saturates so it cannot wrap back to zero.
                    if (s1_read) begin
                        if (r_streak != STREAK_MAX) begin
                            w_streakNext = r_streak + STREAK_ONE;
                        end
                    end else begin
                        w_streakNext = '0;
                    end
                    w_stateNext       = CMD;
                end
            end

            CMD: begin
                if (!m_waitrequest) begin
                    w_mReadNext   = 1'b0;
                    w_beatCntNext = '0;
                    w_stateNext   = DATA;
                end
            end

            DATA: begin
                if (m_readdatavalid) begin
                    w_beatCntNext = r_beatCnt + BURST_ONE;
                end
                if (w_lastBeat) begin
                    w_grantNext = GRANT_NONE;
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Only the granted requester sees the SDRAM handshake; the other one is
    // stalled. Beats are forwarded only in DATA so stray beats that arrive
    // in IDLE or CMD (for example after a reset mid-burst) are dropped.
    assign s0_waitrequest   = (r_state == CMD && r_grant[0]) ? m_waitrequest : 1'b1;
    assign s1_waitrequest   = (r_state == CMD && r_grant[1]) ? m_waitrequest : 1'b1;
    assign s0_readdatavalid = (r_state == DATA) && r_grant[0] && m_readdatavalid;
    assign s1_readdatavalid = (r_state == DATA) && r_grant[1] && m_readdatavalid;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

    assign m_read       = r_mRead;
    assign m_address    = r_mAddress;
    assign m_burstcount = r_mBurstcount;
    assign m_byteenable = 4'b1111;
    assign grant        = r_grant;
    assign busy         = (r_state != IDLE);

endmodule
